// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot and auto-reload modes.
// Word offsets: 0 = CTRL {IM, Mode[1:0], Enable}, 1 = PRESET, 2 = COUNT (read-only),
// 3 = unmapped (reads zero). IRQ is the registered AND of IM and the internal flag.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  state_t      state_r;
  logic [3:0]  ctrl_r;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic        irq_flag_r;

  logic        ctrl_wr_s;
  logic        preset_wr_s;
  logic        enable_s;
  logic        reload_mode_s;
  logic        expire_s;
  logic [3:0]  fsm_ctrl_s;
  logic        fsm_flag_s;
  logic [3:0]  ctrl_nxt_s;
  logic        flag_nxt_s;

  // Bus write decode and FSM condition terms.
  always_comb begin
    ctrl_wr_s     = WE && (Addr == A_CTRL);
    preset_wr_s   = WE && (Addr == A_PRESET);
    enable_s      = ctrl_r[0];
    reload_mode_s = (ctrl_r[2:1] == 2'd1);
    // COUNT of 0 or 1 both expire, so a zero PRESET acts like one and never wraps.
    expire_s      = (state_r == S_CNT) && enable_s && (count_r <= 32'd1);
  end

  // Next CTRL/flag: FSM side effects first, then a bus CTRL write overrides both.
  always_comb begin
    fsm_ctrl_s = ctrl_r;
    fsm_flag_s = irq_flag_r;
    if (expire_s) begin
      fsm_flag_s = 1'b1;
    end else if ((state_r == S_INT) && reload_mode_s) begin
      fsm_flag_s = 1'b0;
    end else begin
      fsm_flag_s = irq_flag_r;
    end
    // Every mode other than auto-reload is one-shot: drop Enable on leaving INT.
    if ((state_r == S_INT) && !reload_mode_s) begin
      fsm_ctrl_s = {ctrl_r[3:1], 1'b0};
    end else begin
      fsm_ctrl_s = ctrl_r;
    end
    if (ctrl_wr_s) begin
      ctrl_nxt_s = Din[3:0];
      flag_nxt_s = 1'b0;
    end else begin
      ctrl_nxt_s = fsm_ctrl_s;
      flag_nxt_s = fsm_flag_s;
    end
  end

  // Read mux: reflects register contents before the current edge.
  always_comb begin
    case (Addr)
      A_CTRL:   Dout = {28'd0, ctrl_r};
      A_PRESET: Dout = preset_r;
      A_COUNT:  Dout = count_r;
      default:  Dout = 32'd0;
    endcase
  end

  // Registers and countdown FSM; IRQ is registered from the next-state IM and flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      ctrl_r     <= 4'd0;
      preset_r   <= 32'd0;
      count_r    <= 32'd0;
      irq_flag_r <= 1'b0;
      IRQ        <= 1'b0;
    end else begin
      ctrl_r     <= ctrl_nxt_s;
      irq_flag_r <= flag_nxt_s;
      IRQ        <= ctrl_nxt_s[3] & flag_nxt_s;
      // A PRESET write only takes effect at the next LOAD.
      if (preset_wr_s) begin
        preset_r <= Din;
      end else begin
        preset_r <= preset_r;
      end
      case (state_r)
        S_IDLE: begin
          if (enable_s) begin
            state_r <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          count_r <= preset_r;
          state_r <= S_CNT;
        end
        S_CNT: begin
          if (!enable_s) begin
            state_r <= S_IDLE;
          end else if (count_r > 32'd1) begin
            count_r <= count_r - 32'd1;
          end else begin
            count_r <= 32'd0;
            state_r <= S_INT;
          end
        end
        S_INT: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: the driver pushes expected Dout/IRQ for each
// cycle (from a behavioural model or a hand-derived constant), a monitor pops
// and compares on the falling edge.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model state.
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_INT  = 3;
  logic [3:0]  m_ctrl   = 4'd0;
  logic [31:0] m_preset = 32'd0;
  logic [31:0] m_count  = 32'd0;
  bit          m_flag   = 1'b0;
  int          m_phase  = PH_IDLE;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer, written from the behavioural rules.
  function automatic void model_step(input bit rst, input bit we, input logic [1:0] a,
                                     input logic [31:0] d);
    logic [3:0]  n_ctrl   = m_ctrl;
    logic [31:0] n_preset = m_preset;
    logic [31:0] n_count  = m_count;
    bit          n_flag   = m_flag;
    int          n_phase  = m_phase;
    if (rst) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = PH_IDLE;
      return;
    end
    case (m_phase)
      PH_IDLE: if (m_ctrl[0]) n_phase = PH_LOAD;
      PH_LOAD: begin n_count = m_preset; n_phase = PH_CNT; end
      PH_CNT: begin
        if (!m_ctrl[0]) n_phase = PH_IDLE;
        else if (m_count > 32'd1) n_count = m_count - 32'd1;
        else begin n_count = 32'd0; n_flag = 1'b1; n_phase = PH_INT; end
      end
      default: begin
        n_phase = PH_IDLE;
        if (m_ctrl[2:1] == 2'd1) n_flag = 1'b0;
        else n_ctrl[0] = 1'b0;
      end
    endcase
    if (we && a == 2'd0) begin n_ctrl = d[3:0]; n_flag = 1'b0; end
    if (we && a == 2'd1) n_preset = d;
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_flag = n_flag; m_phase = n_phase;
  endfunction

  // Drive one cycle; optionally push an expectation (model or constant).
  task automatic drive(input bit rst, input bit we, input logic [1:0] a, input logic [31:0] d,
                       input bit chk, input bit use_c, input logic [31:0] cd, input bit ci,
                       input string tag);
    exp_t e;
    reset = rst; WE = we; Addr = a; Din = d;
    if (chk) begin
      e.tag  = tag;
      e.dout = use_c ? cd : model_read(a);
      e.irq  = use_c ? ci : (m_ctrl[3] & m_flag);
      q.push_back(e);
    end
    @(posedge clk);
    model_step(rst, we, a, d);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    drive(1'b0, 1'b0, a, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, "model_rd");
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d, 1'b1, 1'b0, 32'd0, 1'b0, "model_wr");
  endtask

  task automatic rdc(input logic [1:0] a, input logic [31:0] cd, input bit ci, input string tag);
    drive(1'b0, 1'b0, a, 32'd0, 1'b1, 1'b1, cd, ci, tag);
  endtask

  // Monitor: compares the DUT against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (Dout !== e.dout || IRQ !== e.irq) begin
          bad++;
          $display("FAIL %s: got Dout=%h IRQ=%b, expected Dout=%h IRQ=%b",
                   e.tag, Dout, IRQ, e.dout, e.irq);
        end
      end
    end
  end

  initial begin
    int          r;
    logic [31:0] d;
    logic [31:0] m1_cnt [6];
    m1_cnt[0] = 32'd3; m1_cnt[1] = 32'd2; m1_cnt[2] = 32'd1;
    m1_cnt[3] = 32'd0; m1_cnt[4] = 32'd0; m1_cnt[5] = 32'd0;
    reset = 1'b1; WE = 1'b0; Addr = 2'd0; Din = 32'd0;
    @(posedge clk); #1;

    // Reset defaults, CTRL write ignored while reset is high.
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, "");
    drive(1'b1, 1'b1, 2'd0, 32'hF, 1'b1, 1'b0, 32'd0, 1'b0, "rst_wr");
    rdc(2'd0, 32'd0, 1'b0, "rst_ctrl");
    rdc(2'd1, 32'd0, 1'b0, "rst_preset");
    rdc(2'd2, 32'd0, 1'b0, "rst_count");

    // Mode 0 one-shot, PRESET = 5.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd(2'd2); rd(2'd2);
    rdc(2'd2, 32'd5, 1'b0, "m0_count5");
    rd(2'd2); rd(2'd2); rd(2'd2);
    rdc(2'd2, 32'd1, 1'b0, "m0_count1");
    rdc(2'd2, 32'd0, 1'b1, "m0_irq_rise");
    rdc(2'd0, 32'h8, 1'b1, "m0_enable_clr");
    rdc(2'd0, 32'h8, 1'b1, "m0_irq_hold");
    rdc(2'd0, 32'h8, 1'b1, "m0_irq_hold");
    wr(2'd0, 32'h0);
    rdc(2'd0, 32'h0, 1'b0, "m0_irq_clr");

    // Mode 1 auto-reload, PRESET = 3: pulses at k = 5, 11, 17.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 0; k < 20; k++) begin
      rdc(2'd2, (k < 2) ? 32'd0 : m1_cnt[(k - 2) % 6],
          (k >= 5) && ((k - 5) % 6 == 0), "m1_period");
    end
    wr(2'd0, 32'h0);
    rd(2'd2); rd(2'd2);

    // Masked run: IRQ never rises, Enable still clears after INT.
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 9; k++) begin
      rdc(2'd0, (k <= 6) ? 32'd1 : 32'd0, 1'b0, "mask");
    end

    // Pause at COUNT = 2, then re-enable reloads PRESET.
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h1);
    rd(2'd2); rd(2'd2);
    rdc(2'd2, 32'd6, 1'b0, "pause_count6");
    rd(2'd2);
    rdc(2'd2, 32'd4, 1'b0, "pause_count4");
    drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b1, 32'd1, 1'b0, "pause_wr");
    for (int k = 0; k < 4; k++) rdc(2'd2, 32'd2, 1'b0, "pause_frozen");
    wr(2'd0, 32'h1);
    rdc(2'd2, 32'd2, 1'b0, "reen_idle");
    rdc(2'd2, 32'd2, 1'b0, "reen_load");
    rdc(2'd2, 32'd6, 1'b0, "reen_reload");
    wr(2'd0, 32'h0);
    rd(2'd2); rd(2'd2);

    // Read-only COUNT and unmapped offset.
    wr(2'd2, 32'h1234);
    rdc(2'd2, 32'd4, 1'b0, "ro_count");
    wr(2'd3, 32'hFFFF_FFFF);
    rdc(2'd3, 32'd0, 1'b0, "off3");
    rdc(2'd1, 32'd6, 1'b0, "preset_keep");

    // PRESET = 0: IRQ after t+3, then reset drops it.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    rdc(2'd2, 32'd4, 1'b0, "p0_idle");
    rdc(2'd2, 32'd4, 1'b0, "p0_load");
    rdc(2'd2, 32'd0, 1'b0, "p0_cnt");
    rdc(2'd2, 32'd0, 1'b1, "p0_irq");
    drive(1'b1, 1'b1, 2'd0, 32'hF, 1'b1, 1'b0, 32'd0, 1'b0, "mid_rst");
    rdc(2'd0, 32'd0, 1'b0, "mid_rst_ctrl");
    rdc(2'd2, 32'd0, 1'b0, "mid_rst_count");

    // PRESET write during LOAD: COUNT takes the old value.
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h1);
    rd(2'd2);
    wr(2'd1, 32'd9);
    rdc(2'd2, 32'd7, 1'b0, "load_old");
    rdc(2'd1, 32'd9, 1'b0, "load_new_preset");
    wr(2'd0, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 2) begin
        drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, "rnd_rst");
      end else if (r < 10) begin
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        wr(2'd0, d);
      end else if (r < 16) begin
        wr(2'd1, 32'($urandom_range(0, 8)));
      end else if (r < 19) begin
        wr(2'($urandom_range(2, 3)), d);
      end else begin
        rd(2'($urandom_range(0, 3)));
      end
    end

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
